// File: rtl/proc_pkg.sv
// ============================================================================
// proc_pkg : shared widths, fetch types and reset defaults for the front end
// Rev 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef logic [ADDR_W-1:0] pc_t;
    typedef logic [DATA_W-1:0] instr_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_entry_t;

    localparam pc_t RESET_PC_DEFAULT = 8'h00;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_STALL = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : 2-entry shift FIFO of {pc, instr}; flush beats push/pop
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import proc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] din,
    output logic               full,
    output logic               empty,
    output logic [ENTRY_W-1:0] head
);

    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         w_pop_ok;
    logic         w_push_ok;

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign head  = e0_q;

    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    // Entry 0 is always the head; it is left untouched when the FIFO drains
    // so the head outputs keep showing the last instruction.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_d  = din;
                        cnt_d = 2'd1;
                    end else begin
                        e1_d  = din;
                        cnt_d = 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                    end
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = din;
                    end else begin
                        e0_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/im_fetch.sv
// ============================================================================
// im_fetch : instruction fetch unit driving the IM read bus, with prefetch
// Rev 1.0
// ============================================================================
`default_nettype none

module im_fetch
    import proc_pkg::*;
#(
    parameter int                     ADDR_W      = proc_pkg::ADDR_W,
    parameter int                     DATA_W      = proc_pkg::DATA_W,
    parameter int                     WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0]      RESET_PC    = proc_pkg::RESET_PC_DEFAULT
)
(
    input  logic              CLK,
    input  logic              RST_N,
    output logic [ADDR_W-1:0] ABUS,
    input  logic [DATA_W-1:0] DATABUS,
    output logic [DATA_W-1:0] INSTR,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TARGET
);

    localparam logic [3:0]        WCNT_RELOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PC_INC      = 1;

    logic [ADDR_W-1:0] abus_q, abus_d;
    logic [3:0]        wcnt_q, wcnt_d;
    fetch_state_t      state_q, state_d;

    logic              w_push;
    logic              w_pop;
    logic              w_space;
    logic              w_full;
    logic              w_empty;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;
    logic [ENTRY_W-1:0] w_head_raw;

    assign INSTR_VALID = !w_empty;
    assign ABUS        = abus_q;
    assign INSTR       = w_head.instr;
    assign PC_OUT      = w_head.pc;
    assign w_head      = w_head_raw;

    // A redirect kills the head, so decode's handshake in that cycle is void.
    assign w_pop        = INSTR_VALID && INSTR_READY && !BR_TAKEN;
    assign w_space      = !w_full || w_pop;
    assign w_push_entry = '{pc: abus_q, instr: DATABUS};

    always_comb begin
        abus_d  = abus_q;
        wcnt_d  = wcnt_q;
        state_d = state_q;
        w_push  = 1'b0;
        if (BR_TAKEN) begin
            abus_d  = BR_TARGET;
            wcnt_d  = WCNT_RELOAD;
            state_d = ST_FETCH;
        end else if (state_q == ST_FETCH && wcnt_q != 4'd0) begin
            wcnt_d = wcnt_q - 4'd1;
        end else if (w_space) begin
            // STALL held ABUS steady, so DATABUS is already settled here.
            w_push  = 1'b1;
            abus_d  = abus_q + PC_INC;
            wcnt_d  = WCNT_RELOAD;
            state_d = ST_FETCH;
        end else begin
            state_d = ST_STALL;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            abus_q  <= RESET_PC;
            wcnt_q  <= WCNT_RELOAD;
            state_q <= ST_FETCH;
        end else begin
            abus_q  <= abus_d;
            wcnt_q  <= wcnt_d;
            state_q <= state_d;
        end
    end

    fetch_fifo u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (w_push),
        .pop   (w_pop),
        .flush (BR_TAKEN),
        .din   (w_push_entry),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head_raw)
    );

endmodule

`default_nettype wire

// File: tb/tb_im_fetch.sv
// ============================================================================
// tb_im_fetch : directed self-checking bench for im_fetch (1- and 3-cycle IM)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_im_fetch;

    logic       clk = 1'b0;
    logic       rst_n, rst3_n;
    logic       ready1, br1, ready3, br3;
    logic [7:0] tgt1, tgt3;
    logic [7:0] abus1, data1, instr1, pc1;
    logic [7:0] abus3, data3, instr3, pc3;
    logic       valid1, valid3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Fast memory: data valid within the same cycle.
    assign data1 = abus1 ^ 8'hA5;

    // Slow memory: data only settles two negedges after ABUS changes, so
    // an early sample of a 3-cycle fetch returns the 8'hEE filler.
    logic [7:0] last3 = 8'h00;
    logic [3:0] age3  = 4'd15;
    always @(negedge clk) begin
        if (abus3 !== last3) begin
            last3 <= abus3;
            age3  <= 4'd0;
        end else if (age3 != 4'd15) begin
            age3 <= age3 + 4'd1;
        end
    end
    assign data3 = (age3 >= 4'd2) ? (last3 ^ 8'hA5) : 8'hEE;

    im_fetch u_dut1 (
        .CLK(clk), .RST_N(rst_n), .ABUS(abus1), .DATABUS(data1),
        .INSTR(instr1), .PC_OUT(pc1), .INSTR_VALID(valid1),
        .INSTR_READY(ready1), .BR_TAKEN(br1), .BR_TARGET(tgt1)
    );

    im_fetch #(.WAIT_CYCLES(3)) u_dut3 (
        .CLK(clk), .RST_N(rst3_n), .ABUS(abus3), .DATABUS(data3),
        .INSTR(instr3), .PC_OUT(pc3), .INSTR_VALID(valid3),
        .INSTR_READY(ready3), .BR_TAKEN(br3), .BR_TARGET(tgt3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] p;
        rst_n = 1'b0; rst3_n = 1'b0;
        ready1 = 1'b1; br1 = 1'b0; tgt1 = 8'h00;
        ready3 = 1'b1; br3 = 1'b0; tgt3 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {7'd0, valid1}, 8'h00);
        chk("rst_abus",  abus1,  8'h00);
        chk("rst_instr", instr1, 8'h00);
        chk("rst_pc",    pc1,    8'h00);
        chk("rst3_abus", abus3,  8'h00);
        rst_n = 1'b1;

        // Straight-line run, one instruction per clock from edge 1.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("run_valid", {7'd0, valid1}, 8'h01);
            chk("run_pc",    pc1,    i[7:0]);
            chk("run_instr", instr1, i[7:0] ^ 8'hA5);
        end

        // Back-pressure from a fresh reset.
        rst_n = 1'b0; ready1 = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (6) step();
        chk("bp_abus",  abus1,  8'h02);
        chk("bp_pc",    pc1,    8'h00);
        chk("bp_instr", instr1, 8'hA5);
        chk("bp_valid", {7'd0, valid1}, 8'h01);
        ready1 = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("bp_rel_pc",    pc1,    i[7:0]);
            chk("bp_rel_instr", instr1, i[7:0] ^ 8'hA5);
        end
        chk("bp_rel_abus", abus1, 8'h05);

        // Redirect with a same-cycle pop.
        br1 = 1'b1; tgt1 = 8'h40;
        step();
        br1 = 1'b0;
        chk("br_valid",      {7'd0, valid1}, 8'h00);
        chk("br_abus",       abus1,  8'h40);
        chk("br_hold_pc",    pc1,    8'h03);
        chk("br_hold_instr", instr1, 8'hA6);
        step();
        chk("br_t_valid", {7'd0, valid1}, 8'h01);
        chk("br_t_pc",    pc1,    8'h40);
        chk("br_t_instr", instr1, 8'hE5);
        step();
        chk("br_t1_pc",    pc1,    8'h41);
        chk("br_t1_instr", instr1, 8'hE4);

        // Wrap-around.
        br1 = 1'b1; tgt1 = 8'hFE;
        step();
        br1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            p = 8'hFE + 8'(i);
            chk("wrap_pc",    pc1,    p);
            chk("wrap_instr", instr1, p ^ 8'hA5);
        end

        // Async reset with two entries buffered.
        ready1 = 1'b0;
        repeat (2) step();
        chk("ar_pre_valid", {7'd0, valid1}, 8'h01);
        chk("ar_pre_abus",  abus1, 8'h03);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {7'd0, valid1}, 8'h00);
        chk("ar_abus",  abus1,  8'h00);
        chk("ar_instr", instr1, 8'h00);
        chk("ar_pc",    pc1,    8'h00);
        #1;
        rst_n = 1'b1; ready1 = 1'b1;
        step();
        chk("ar_re_valid", {7'd0, valid1}, 8'h01);
        chk("ar_re_pc",    pc1,    8'h00);
        chk("ar_re_instr", instr1, 8'hA5);
        chk("ar_re_abus",  abus1,  8'h01);

        // Slow memory, WAIT_CYCLES=3.
        rst3_n = 1'b1;
        step();
        chk("s_e1_valid", {7'd0, valid3}, 8'h00);
        chk("s_e1_abus",  abus3, 8'h00);
        step();
        chk("s_e2_valid", {7'd0, valid3}, 8'h00);
        chk("s_e2_abus",  abus3, 8'h00);
        step();
        chk("s_e3_valid", {7'd0, valid3}, 8'h01);
        chk("s_e3_pc",    pc3,    8'h00);
        chk("s_e3_instr", instr3, 8'hA5);
        chk("s_e3_abus",  abus3,  8'h01);
        step();
        chk("s_e4_valid", {7'd0, valid3}, 8'h00);
        chk("s_e4_abus",  abus3, 8'h01);
        step();
        chk("s_e5_abus",  abus3, 8'h01);
        step();
        chk("s_e6_valid", {7'd0, valid3}, 8'h01);
        chk("s_e6_pc",    pc3,    8'h01);
        chk("s_e6_instr", instr3, 8'hA4);
        chk("s_e6_abus",  abus3,  8'h02);
        step();
        chk("s_e7_valid", {7'd0, valid3}, 8'h00);
        step();
        chk("s_e8_abus",  abus3, 8'h02);
        br3 = 1'b1; tgt3 = 8'h80;
        step();
        br3 = 1'b0;
        chk("s_br_abus",  abus3, 8'h80);
        chk("s_br_valid", {7'd0, valid3}, 8'h00);
        chk("s_br_instr", instr3, 8'hA4);
        step();
        chk("s_br1_valid", {7'd0, valid3}, 8'h00);
        step();
        chk("s_br2_valid", {7'd0, valid3}, 8'h00);
        chk("s_br2_abus",  abus3, 8'h80);
        step();
        chk("s_bt_valid", {7'd0, valid3}, 8'h01);
        chk("s_bt_pc",    pc3,    8'h80);
        chk("s_bt_instr", instr3, 8'h25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/im_fetch.md
# im_fetch

Instruction fetch unit: the initiator side of the instruction-memory read bus. It drives the 8-bit address bus toward instruction memory and samples the returned instruction byte after a fixed number of clock cycles. It holds fetched instructions in a 2-entry prefetch buffer and delivers them to decode over a valid/ready handshake. It sits between the IM block and the decode stage, owns the fetch PC, and accepts branch redirects from execute.

## Interface
- ADDR_W, 8, address/PC width
- DATA_W, 8, instruction width
- WAIT_CYCLES, 1, clock edges from an ABUS change to the DATABUS sample edge; legal range 1..15
- RESET_PC, 8'h00, fetch PC after reset

- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- ABUS  out  ADDR_W  address to instruction memory; registered
- DATABUS  in  DATA_W  instruction byte from memory; the unit never drives it
- INSTR  out  DATA_W  instruction at buffer head
- PC_OUT  out  ADDR_W  address that INSTR was fetched from
- INSTR_VALID  out  1  buffer non-empty
- INSTR_READY  in  1  decode accepts head; pop when VALID&&READY
- BR_TAKEN  in  1  redirect request, single-cycle pulse
- BR_TARGET  in  ADDR_W  redirect address, valid with BR_TAKEN

## Operation
- State: fetch PC (equal to ABUS), wait counter `wcnt` (4 bits), FSM {FETCH, STALL}, 2-entry FIFO of {PC, INSTR}.
- Reset values: ABUS=RESET_PC, wcnt=WAIT_CYCLES-1, FSM=FETCH, FIFO empty, INSTR=0, PC_OUT=0, INSTR_VALID=0.
- FETCH: while wcnt≠0, decrement wcnt. When wcnt==0 and there is space (FIFO not full, or a pop occurs this cycle):
  - push {ABUS, DATABUS};
  - ABUS←ABUS+1, with modulo-2^ADDR_W wrap, so 8'hFF→8'h00;
  - wcnt←WAIT_CYCLES-1.
- FETCH→STALL: wcnt==0 and FIFO full with no pop. ABUS is held.
- STALL: ABUS is stable, so the data stays valid. On the first cycle with space, sample immediately (push, advance ABUS, reload wcnt) and go to FETCH.
- Redirect (BR_TAKEN=1), highest priority:
  - flush the FIFO;
  - discard any sample due this cycle;
  - ABUS←BR_TARGET, wcnt←WAIT_CYCLES-1, FSM←FETCH.
  - A pop in the same cycle is ignored. The head is flushed, and decode must not consume it.
- Simultaneous push and pop on a full FIFO: both take effect, and the count stays at 2.
- INSTR/PC_OUT always reflect the FIFO head. They hold their last value when empty, and are 0 after reset.
- Reset mid-fetch: all state returns to reset values asynchronously. The in-flight fetch is lost.

## Timing
- Throughput: one instruction per WAIT_CYCLES clocks while decode is ready.
- Latency:
  - after reset release: first INSTR_VALID=1 after edge WAIT_CYCLES;
  - after a redirect edge: first target instruction valid WAIT_CYCLES edges later.
- ABUS changes only on a rising CLK edge. DATABUS must be settled within WAIT_CYCLES clock periods of that edge, which means clock period × WAIT_CYCLES must exceed the memory access delay.
- INSTR_VALID may not depend combinationally on INSTR_READY. INSTR_READY may only feed the pop/push enables.
- BR_TAKEN is sampled only on the rising edge. No combinational path from BR_TARGET to ABUS.

## Structure
- Shared package proc_pkg holds:
  - ADDR_W/DATA_W constants;
  - pc_t and instr_t typedefs;
  - the fetch-entry struct {pc_t pc; instr_t instr};
  - the RESET_PC default.
- One sub-module, fetch_fifo: 2-entry synchronous FIFO of fetch entries. It has push, pop, flush, full, empty and head, uses RST_N asynchronous clear, and flush takes priority over push/pop.
- im_fetch top contains the PC register, wcnt, the FSM and the redirect logic.

## Test plan
- Reset then straight-line run: memory holds ram[i]=i^8'hA5, WAIT_CYCLES=1, READY=1. Required: INSTR sequence A5,A4,A7… with PC_OUT 0,1,2…; one instruction per clock; first valid after edge 1.
- Back-pressure: hold READY=0 for 6 cycles. Required: FIFO fills with PCs 0 and 1; ABUS holds at 2 in STALL. Then raise READY. Required: ram[2] is pushed on the first ready cycle, with no duplicates or skips.
- Redirect mid-stream: pulse BR_TAKEN with BR_TARGET=8'h40 while VALID=1 and READY=1. Required:
  - old entries flushed;
  - next delivered PC_OUT=8'h40 with INSTR=ram[64], arriving WAIT_CYCLES edges later;
  - the same-cycle pop is not counted.
- Wrap-around: redirect to 8'hFE. Required: PC_OUT sequence FE,FF,00,01.
- Slow memory: WAIT_CYCLES=3. Required:
  - ABUS stable for 3 clocks per fetch;
  - sample taken at edge 3 after the change;
  - a redirect arriving during the wait aborts the fetch, and the old address's data never appears.
- Asynchronous reset mid-fetch: assert RST_N=0 between edges with 2 entries buffered. Required: INSTR_VALID=0 and ABUS=RESET_PC immediately, without waiting for a clock; fetching restarts from RESET_PC after release.
